ctrl_sequencer: RTL and testbench

//  Host-side initiator for the PE-array control FSM: accepts one layer descriptor per valid/ready handshake.

---
 rtl/ctrl_sequencer_if.sv | 24 ++
 rtl/ctrl_sequencer.sv | 121 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: layer-descriptor valid/ready handshake between the descriptor source and the sequencer
interface ctrl_sequencer_if #(
  parameter int N = 3,
  parameter int RUN_WIDTH = 16
);
  localparam int NUM_COL_WIDTH = $clog2(N + 1);
  localparam int SEL_WIDTH = $clog2(N);
  logic cfg_valid;
  logic cfg_ready;
  logic [NUM_COL_WIDTH-1:0] cfg_col_num;
  logic [NUM_COL_WIDTH-1:0] cfg_row_num;
  logic [SEL_WIDTH-1:0] cfg_f_sel;
  logic cfg_en_adder_1;
  logic cfg_en_adder_2;
  logic [RUN_WIDTH-1:0] cfg_run_len;
  modport master (
    output cfg_valid, cfg_col_num, cfg_row_num, cfg_f_sel, cfg_en_adder_1, cfg_en_adder_2, cfg_run_len,
    input cfg_ready
  );
  modport slave (
    input cfg_valid, cfg_col_num, cfg_row_num, cfg_f_sel, cfg_en_adder_1, cfg_en_adder_2, cfg_run_len,
    output cfg_ready
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: steps the PE-array control FSM through reset -> load -> ready -> start -> run -> reset per descriptor
module ctrl_sequencer #(
  parameter int N = 3,
  parameter int NUM_COL_WIDTH = $clog2(N + 1),
  parameter int SEL_WIDTH = $clog2(N),
  parameter int RUN_WIDTH = 16,
  parameter int LOAD_CYCLES = N,
  parameter int READY_CYCLES = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     f_sel_rst,
  ctrl_sequencer_if.slave          cfg,
  input  logic                     abort_i,
  output logic                     rst_o,
  output logic                     load_o,
  output logic                     ready_o,
  output logic                     start_op_o,
  output logic [NUM_COL_WIDTH-1:0] column_num_o,
  output logic [NUM_COL_WIDTH-1:0] row_num_o,
  output logic [SEL_WIDTH-1:0]     f_sel_o,
  output logic                     en_adder_1_o,
  output logic                     en_adder_2_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, START, RUN, FLUSH} state_t;
  localparam logic [NUM_COL_WIDTH-1:0] NMAX = NUM_COL_WIDTH'(N);
  localparam logic [RUN_WIDTH-1:0] ONE = RUN_WIDTH'(1);
  state_t st, nxt;
  logic [RUN_WIDTH-1:0] cnt, ncnt, run_len;
  logic acc, ok, active, abt;
  assign acc = cfg.cfg_valid & cfg.cfg_ready;
  assign ok = cfg.cfg_col_num != '0 && cfg.cfg_col_num <= NMAX && cfg.cfg_row_num != '0 && cfg.cfg_row_num <= NMAX;
  assign active = st inside {LOAD, READY, START, RUN};
  // next phase and the remaining-cycle budget it starts with; abort overrides any phase-end transition
  always_comb begin
    nxt = st;
    ncnt = cnt;
    case (st)
      IDLE: if (acc && ok) begin
        nxt = LOAD;
        ncnt = RUN_WIDTH'(LOAD_CYCLES - 1);
      end
      LOAD: if (cnt == '0) begin
        nxt = READY;
        ncnt = RUN_WIDTH'(READY_CYCLES - 1);
      end else ncnt = cnt - ONE;
      READY: if (cnt == '0) begin
        nxt = START;
        ncnt = '0;
      end else ncnt = cnt - ONE;
      START: if (run_len != '0) begin
        nxt = RUN;
        ncnt = run_len - ONE;
      end else begin
        nxt = FLUSH;
        ncnt = RUN_WIDTH'(RST_CYCLES - 1);
      end
      RUN: if (cnt == '0) begin
        nxt = FLUSH;
        ncnt = RUN_WIDTH'(RST_CYCLES - 1);
      end else ncnt = cnt - ONE;
      FLUSH: if (cnt == '0) begin
        nxt = IDLE;
        ncnt = '0;
      end else ncnt = cnt - ONE;
      default: begin
        nxt = IDLE;
        ncnt = '0;
      end
    endcase
    if (abort_i && active) begin
      nxt = FLUSH;
      ncnt = RUN_WIDTH'(RST_CYCLES - 1);
    end
  end
  // state, counters, captured descriptor and all outputs registered from the next state
  always_ff @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      st <= IDLE;
      cnt <= '0;
      run_len <= '0;
      abt <= 1'b0;
      rst_o <= 1'b1;
      load_o <= 1'b0;
      ready_o <= 1'b0;
      start_op_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      cfg.cfg_ready <= 1'b0;
      column_num_o <= '0;
      row_num_o <= '0;
      f_sel_o <= '0;
      en_adder_1_o <= 1'b0;
      en_adder_2_o <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= ncnt;
      abt <= (abort_i && active) ? 1'b1 : (acc && ok) ? 1'b0 : abt;
      rst_o <= nxt == IDLE || nxt == FLUSH;
      load_o <= nxt == LOAD;
      ready_o <= nxt == READY;
      start_op_o <= nxt == START;
      busy_o <= nxt != IDLE;
      done_o <= st == FLUSH && nxt == IDLE && !abt;
      err_o <= acc && !ok;
      cfg.cfg_ready <= nxt == IDLE;
      if (acc && ok) begin
        run_len <= cfg.cfg_run_len;
        column_num_o <= cfg.cfg_col_num;
        row_num_o <= cfg.cfg_row_num;
        f_sel_o <= cfg.cfg_f_sel;
        en_adder_1_o <= cfg.cfg_en_adder_1;
        en_adder_2_o <= cfg.cfg_en_adder_2;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: timeline model plus directed passes for ctrl_sequencer
module tb_ctrl_sequencer;
  localparam int N = 3;
  localparam int L = 3;
  localparam int R = 1;
  localparam int RS = 2;
  logic clk_i = 1'b0;
  logic f_sel_rst = 1'b1;
  logic abort_i = 1'b0;
  logic rst_o, load_o, ready_o, start_op_o, en_adder_1_o, en_adder_2_o, busy_o, done_o, err_o;
  logic [1:0] column_num_o, row_num_o, f_sel_o;
  int checks = 0;
  int failures = 0;
  int c = 0;
  int a = 0;
  int fs = -100;
  int ab = 1;
  int e;
  logic idle;
  logic m_err = 1'b0;
  int m_col = 0;
  int m_row = 0;
  int m_fsel = 0;
  logic m_e1 = 1'b0;
  logic m_e2 = 1'b0;

  ctrl_sequencer_if #(.N(N)) cfg();

  ctrl_sequencer dut (
    .clk_i(clk_i),
    .f_sel_rst(f_sel_rst),
    .cfg(cfg),
    .abort_i(abort_i),
    .rst_o(rst_o),
    .load_o(load_o),
    .ready_o(ready_o),
    .start_op_o(start_op_o),
    .column_num_o(column_num_o),
    .row_num_o(row_num_o),
    .f_sel_o(f_sel_o),
    .en_adder_1_o(en_adder_1_o),
    .en_adder_2_o(en_adder_2_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic chkv(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic desc(input int col, input int row, input int fsel, input logic e1, input logic e2, input int run);
    cfg.cfg_col_num = 2'(col);
    cfg.cfg_row_num = 2'(row);
    cfg.cfg_f_sel = 2'(fsel);
    cfg.cfg_en_adder_1 = e1;
    cfg.cfg_en_adder_2 = e2;
    cfg.cfg_run_len = 16'(run);
  endtask

  // timeline model: a pass accepted in cycle a occupies cycles a+1 .. fs-1, flush fs .. fs+RS-1
  always @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      c = 0;
      fs = -100;
      ab = 1;
      m_err = 1'b0;
      m_col = 0;
      m_row = 0;
      m_fsel = 0;
      m_e1 = 1'b0;
      m_e2 = 1'b0;
    end else begin
      m_err = 1'b0;
      if (c >= fs + RS) begin
        if (c >= 1 && cfg.cfg_valid) begin
          if (int'(cfg.cfg_col_num) >= 1 && int'(cfg.cfg_col_num) <= N && int'(cfg.cfg_row_num) >= 1 && int'(cfg.cfg_row_num) <= N) begin
            a = c;
            fs = c + L + R + 2 + int'(cfg.cfg_run_len);
            ab = 0;
            m_col = int'(cfg.cfg_col_num);
            m_row = int'(cfg.cfg_row_num);
            m_fsel = int'(cfg.cfg_f_sel);
            m_e1 = cfg.cfg_en_adder_1;
            m_e2 = cfg.cfg_en_adder_2;
          end else m_err = 1'b1;
        end
      end else if (c < fs && abort_i) begin
        fs = c + 1;
        ab = 1;
      end
      c++;
    end
  end

  // compare every cycle against the timeline
  always @(negedge clk_i) begin
    idle = c >= fs + RS;
    e = c - a;
    chk1("rst_o", rst_o, idle || c >= fs);
    chk1("busy_o", busy_o, !idle);
    chk1("cfg_ready", cfg.cfg_ready, idle && c >= 1);
    chk1("load_o", load_o, !idle && c < fs && e <= L);
    chk1("ready_o", ready_o, !idle && c < fs && e > L && e <= L + R);
    chk1("start_op_o", start_op_o, !idle && c < fs && e == L + R + 1);
    chk1("done_o", done_o, c == fs + RS && ab == 0);
    chk1("err_o", err_o, m_err);
    chkv("column_num_o", int'(column_num_o), m_col);
    chkv("row_num_o", int'(row_num_o), m_row);
    chkv("f_sel_o", int'(f_sel_o), m_fsel);
    chk1("en_adder_1_o", en_adder_1_o, m_e1);
    chk1("en_adder_2_o", en_adder_2_o, m_e2);
  end

  initial begin
    cfg.cfg_valid = 1'b0;
    desc(0, 0, 0, 1'b0, 1'b0, 0);
    @(negedge clk_i);
    chk1("lit_reset_rst", rst_o, 1'b1);
    chk1("lit_reset_cfg_ready", cfg.cfg_ready, 1'b0);
    chk1("lit_reset_busy", busy_o, 1'b0);
    chkv("lit_reset_col", int'(column_num_o), 0);
    f_sel_rst = 1'b0;
    @(negedge clk_i);
    chk1("lit_ready_after_release", cfg.cfg_ready, 1'b1);
    desc(3, 2, 2, 1'b1, 1'b0, 5);
    cfg.cfg_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_i);
      cfg.cfg_valid = 1'b0;
      chk1("lit_p1_load", load_o, k <= 3);
      chk1("lit_p1_ready", ready_o, k == 4);
      chk1("lit_p1_start", start_op_o, k == 5);
      chk1("lit_p1_rst", rst_o, k >= 11);
      chk1("lit_p1_done", done_o, k == 13);
      chk1("lit_p1_busy", busy_o, k <= 12);
      chkv("lit_p1_col", int'(column_num_o), 3);
      chkv("lit_p1_row", int'(row_num_o), 2);
      chkv("lit_p1_fsel", int'(f_sel_o), 2);
    end
    desc(0, 1, 1, 1'b0, 1'b1, 4);
    cfg.cfg_valid = 1'b1;
    @(negedge clk_i);
    cfg.cfg_valid = 1'b0;
    chk1("lit_bad_col_err", err_o, 1'b1);
    chk1("lit_bad_col_busy", busy_o, 1'b0);
    chk1("lit_bad_col_rst", rst_o, 1'b1);
    chkv("lit_bad_col_keep", int'(column_num_o), 3);
    desc(2, 0, 1, 1'b0, 1'b1, 4);
    cfg.cfg_valid = 1'b1;
    @(negedge clk_i);
    cfg.cfg_valid = 1'b0;
    chk1("lit_bad_row_err", err_o, 1'b1);
    chkv("lit_bad_row_keep", int'(row_num_o), 2);
    @(negedge clk_i);
    chk1("lit_err_one_cycle", err_o, 1'b0);
    desc(3, 3, 1, 1'b0, 1'b1, 0);
    cfg.cfg_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i);
      cfg.cfg_valid = 1'b0;
      chk1("lit_r0_start", start_op_o, k == 5);
      chk1("lit_r0_rst", rst_o, k >= 6);
      chk1("lit_r0_done", done_o, k == 8);
    end
    desc(1, 1, 0, 1'b1, 1'b1, 5);
    cfg.cfg_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      cfg.cfg_valid = 1'b0;
      abort_i = k == 7;
      chk1("lit_ab_rst", rst_o, k >= 8);
      chk1("lit_ab_busy", busy_o, k <= 9);
      chk1("lit_ab_done", done_o, 1'b0);
    end
    desc(2, 2, 1, 1'b0, 1'b0, 2);
    cfg.cfg_valid = 1'b1;
    @(negedge clk_i);
    cfg.cfg_valid = 1'b0;
    @(negedge clk_i);
    #2 f_sel_rst = 1'b1;
    #1;
    chk1("lit_mid_rst_load", load_o, 1'b0);
    chk1("lit_mid_rst_rst", rst_o, 1'b1);
    chk1("lit_mid_rst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    f_sel_rst = 1'b0;
    @(negedge clk_i);
    chk1("lit_mid_rst_ready", cfg.cfg_ready, 1'b1);
    chk1("lit_mid_rst_done", done_o, 1'b0);
    desc(2, 1, 0, 1'b1, 1'b1, 1);
    cfg.cfg_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (k == 1) desc(3, 3, 2, 1'b0, 1'b0, 0);
      chk1("lit_b2b_done", done_o, k == 9);
      chk1("lit_b2b_load", load_o, k <= 3 || k == 10);
      chkv("lit_b2b_col", int'(column_num_o), k == 10 ? 3 : 2);
    end
    cfg.cfg_valid = 1'b0;
    repeat (12) @(negedge clk_i);
    chk1("lit_final_idle", busy_o, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
